ahb_slave_arbiter: RTL and testbench

- Per-slave arbiter placed in front of the AHB slave-side payload mux.
- Decides which master owns the slave's address phase and drives the one-hot select consumed by that mux.
- Registers the data-phase owner so the slave's response (HRDATA/HRESP/HREADYOUT) is routed back to the correct master through the master-side response mux.
- One instance per slave port, generated alongside the slave mux.

---
 rtl/ahb_slave_arbiter_pkg.sv | 39 +++
 rtl/ahb_rr_picker.sv | 29 ++
 rtl/ahb_slave_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB encodings and arbiter state type for the slave-side arbiters.
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN,
        ARB_BURST,
        ARB_HOLD
    } arb_state_e;

    // Fixed-length beat count; SINGLE and INCR report 1 since neither has a known length.
    function automatic logic [4:0] burst_beats(input hburst_e burst);
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  burst_beats = 5'd4;
            BURST_WRAP8,  BURST_INCR8:  burst_beats = 5'd8;
            BURST_WRAP16, BURST_INCR16: burst_beats = 5'd16;
            default:                    burst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after
// index ptr, wrapping around; all-zero when nobody requests.
module ahb_rr_picker #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin address-phase owner with burst/INCR hold and a
// registered data-phase owner. Define AHB_ARB_LOCK_EN to keep HMASTLOCK sequences owned.
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int CHANNEL_NUM = 2,
    parameter int BEAT_W      = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [CHANNEL_NUM-1:0]   req,
    input  logic [2*CHANNEL_NUM-1:0] htrans,
    input  logic [3*CHANNEL_NUM-1:0] hburst,
    input  logic [CHANNEL_NUM-1:0]   hmastlock,
    input  logic                     hready_slv,
    output logic [CHANNEL_NUM-1:0]   addr_sel,
    output logic [CHANNEL_NUM-1:0]   data_sel,
    output logic [CHANNEL_NUM-1:0]   hwait
);

    localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    arb_state_e             state_q,    state_d;
    logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
    logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
    logic [BEAT_W-1:0]      cnt_q,      cnt_d;
    logic [PTR_W-1:0]       ptr_q,      ptr_d;

    htrans_e                own_trans;
    hburst_e                own_burst;
    logic                   start_keep, keep;
    arb_state_e             start_state, keep_state;
    logic [BEAT_W-1:0]      start_cnt,  keep_cnt;
    logic [CHANNEL_NUM-1:0] pick;
    logic [PTR_W-1:0]       pick_ptr;

    // ptr_q holds the highest-priority index, i.e. one past the last winner.
    ahb_rr_picker #(.N(CHANNEL_NUM), .PTR_W(PTR_W)) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick)
    );

    always_comb begin
        pick_ptr = ptr_q;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (pick[i]) pick_ptr = PTR_W'((i + 1) % CHANNEL_NUM);
        end
    end

    always_comb begin
        own_trans = TRANS_IDLE;
        own_burst = BURST_SINGLE;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (addr_sel_q[i]) begin
                own_trans = htrans_e'(htrans[2*i +: 2]);
                own_burst = hburst_e'(hburst[3*i +: 3]);
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic own_lock;
    assign own_lock = |(hmastlock & addr_sel_q);
`else
    logic lock_unused;
    assign lock_unused = ^hmastlock;
`endif

    // Hold decision for an owner starting a new transfer.
    always_comb begin
        start_keep  = 1'b0;
        start_state = ARB_OWN;
        start_cnt   = '0;
        if (own_trans == TRANS_NONSEQ && burst_beats(own_burst) > 5'd1) begin
            start_keep  = 1'b1;
            start_state = ARB_BURST;
            start_cnt   = BEAT_W'(burst_beats(own_burst) - 5'd1);
        end else if (own_burst == BURST_INCR && own_trans != TRANS_IDLE) begin
            start_keep  = 1'b1;
            start_state = ARB_HOLD;
        end else if (own_trans == TRANS_BUSY) begin
            start_keep  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_sel_d = addr_sel_q;
        data_sel_d = data_sel_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        keep       = 1'b0;
        keep_state = state_q;
        keep_cnt   = cnt_q;

        case (state_q)
            ARB_OWN: begin
                keep       = start_keep;
                keep_state = start_state;
                keep_cnt   = start_cnt;
            end
            ARB_BURST: begin
                case (own_trans)
                    TRANS_SEQ: begin
                        keep     = (cnt_q != BEAT_W'(1));
                        keep_cnt = cnt_q - BEAT_W'(1);
                    end
                    TRANS_BUSY: keep = 1'b1;
                    TRANS_NONSEQ: begin
                        keep       = start_keep;
                        keep_state = start_state;
                        keep_cnt   = start_cnt;
                    end
                    default: keep = 1'b0;
                endcase
            end
            ARB_HOLD: begin
                keep = !(own_trans == TRANS_IDLE ||
                         (own_trans == TRANS_NONSEQ && own_burst != BURST_INCR));
            end
            default: keep = 1'b0;
        endcase

`ifdef AHB_ARB_LOCK_EN
        if (own_lock) begin
            keep       = 1'b1;
            keep_state = ARB_HOLD;
            keep_cnt   = '0;
        end
`endif

        // A slave wait state freezes every register.
        if (hready_slv) begin
            data_sel_d = (own_trans == TRANS_NONSEQ || own_trans == TRANS_SEQ) ? addr_sel_q : '0;
            if (keep) begin
                state_d = keep_state;
                cnt_d   = keep_cnt;
            end else begin
                cnt_d      = '0;
                addr_sel_d = pick;
                if (|pick) begin
                    state_d = ARB_OWN;
                    ptr_d   = pick_ptr;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ARB_IDLE;
            addr_sel_q <= '0;
            data_sel_q <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_sel_q <= addr_sel_d;
            data_sel_q <= data_sel_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign addr_sel = addr_sel_q;
    assign data_sel = data_sel_q;
    assign hwait    = req & ~addr_sel_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter: per-cycle vectors push expected outputs into a
// queue that a negedge monitor pops and compares.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I4 = 3'b011, I8 = 3'b101, I16 = 3'b111;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [1:0] req = '0;
    logic [3:0] htrans = '0;
    logic [5:0] hburst = '0;
    logic [1:0] hmastlock = '0;
    logic       hready_slv = 1'b1;
    logic [1:0] addr_sel, data_sel, hwait;

    ahb_slave_arbiter #(.CHANNEL_NUM(2), .BEAT_W(4)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .req        (req),
        .htrans     (htrans),
        .hburst     (hburst),
        .hmastlock  (hmastlock),
        .hready_slv (hready_slv),
        .addr_sel   (addr_sel),
        .data_sel   (data_sel),
        .hwait      (hwait)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] d;
        logic [1:0] w;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // One bus cycle: drive inputs after the edge and queue the outputs expected during it.
    task automatic cyc(input string name, input logic [1:0] r,
                       input logic [1:0] t0, input logic [2:0] b0, input logic l0,
                       input logic [1:0] t1, input logic [2:0] b1, input logic hr,
                       input logic [1:0] ea, input logic [1:0] ed, input logic [1:0] ew);
        @(posedge HCLK);
        #1;
        req        = r;
        htrans     = {t1, t0};
        hburst     = {b1, b0};
        hmastlock  = {1'b0, l0};
        hready_slv = hr;
        exp_q.push_back({ea, ed, ew});
        name_q.push_back(name);
    endtask

    initial begin
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                check({mon_n, ".addr_sel"}, addr_sel, mon_e.a);
                check({mon_n, ".data_sel"}, data_sel, mon_e.d);
                check({mon_n, ".hwait"},    hwait,    mon_e.w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++)
            cyc("R", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);

        // Simultaneous SINGLE requests
        cyc("A1", 2'b11, NS,  SGL, 0, NS,  SGL, 1, 2'b00, 2'b00, 2'b11);
        cyc("A2", 2'b11, NS,  SGL, 0, NS,  SGL, 1, 2'b01, 2'b00, 2'b10);
        cyc("A3", 2'b10, IDL, SGL, 0, NS,  SGL, 1, 2'b10, 2'b01, 2'b00);
        cyc("A4", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b10, 2'b10, 2'b00);
        cyc("A5", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);

        // INCR4 by master 0 while master 1 waits
        cyc("B1", 2'b11, NS,  I4,  0, NS,  SGL, 1, 2'b00, 2'b00, 2'b11);
        cyc("B2", 2'b11, NS,  I4,  0, NS,  SGL, 1, 2'b01, 2'b00, 2'b10);
        cyc("B3", 2'b10, SQ,  I4,  0, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("B4", 2'b10, SQ,  I4,  0, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("B5", 2'b10, SQ,  I4,  0, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("B6", 2'b10, IDL, SGL, 0, NS,  SGL, 1, 2'b10, 2'b01, 2'b00);
        cyc("B7", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b10, 2'b10, 2'b00);
        cyc("B8", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);

        // INCR4 with a three-cycle slave stall at beat 2
        cyc("C1",  2'b11, NS,  I4,  0, NS,  SGL, 1, 2'b00, 2'b00, 2'b11);
        cyc("C2",  2'b11, NS,  I4,  0, NS,  SGL, 1, 2'b01, 2'b00, 2'b10);
        cyc("C3",  2'b10, SQ,  I4,  0, NS,  SGL, 0, 2'b01, 2'b01, 2'b10);
        cyc("C4",  2'b10, SQ,  I4,  0, NS,  SGL, 0, 2'b01, 2'b01, 2'b10);
        cyc("C5",  2'b10, SQ,  I4,  0, NS,  SGL, 0, 2'b01, 2'b01, 2'b10);
        cyc("C6",  2'b10, SQ,  I4,  0, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("C7",  2'b10, SQ,  I4,  0, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("C8",  2'b10, SQ,  I4,  0, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("C9",  2'b10, IDL, SGL, 0, NS,  SGL, 1, 2'b10, 2'b01, 2'b00);
        cyc("C10", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b10, 2'b10, 2'b00);
        cyc("C11", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);

        // Master 1 INCR with BUSY, master 0 waiting
        cyc("D1", 2'b10, IDL, SGL, 0, NS,  INC, 1, 2'b00, 2'b00, 2'b10);
        cyc("D2", 2'b10, IDL, SGL, 0, NS,  INC, 1, 2'b10, 2'b00, 2'b00);
        cyc("D3", 2'b01, NS,  SGL, 0, BSY, INC, 1, 2'b10, 2'b10, 2'b01);
        cyc("D4", 2'b01, NS,  SGL, 0, SQ,  INC, 1, 2'b10, 2'b00, 2'b01);
        cyc("D5", 2'b01, NS,  SGL, 0, IDL, INC, 1, 2'b10, 2'b10, 2'b01);
        cyc("D6", 2'b01, NS,  SGL, 0, IDL, SGL, 1, 2'b01, 2'b00, 2'b00);
        cyc("D7", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b01, 2'b01, 2'b00);
        cyc("D8", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);

        // Master 0 locked SINGLEs against master 1
`ifdef AHB_ARB_LOCK_EN
        cyc("E1", 2'b01, NS,  SGL, 1, IDL, SGL, 1, 2'b00, 2'b00, 2'b01);
        cyc("E2", 2'b11, NS,  SGL, 1, NS,  SGL, 1, 2'b01, 2'b00, 2'b10);
        cyc("E3", 2'b11, NS,  SGL, 1, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("E4", 2'b11, NS,  SGL, 1, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("E5", 2'b10, IDL, SGL, 0, NS,  SGL, 1, 2'b01, 2'b01, 2'b10);
        cyc("E6", 2'b10, IDL, SGL, 0, NS,  SGL, 1, 2'b10, 2'b00, 2'b00);
        cyc("E7", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b10, 2'b10, 2'b00);
        cyc("E8", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);
`else
        cyc("E1", 2'b01, NS,  SGL, 1, IDL, SGL, 1, 2'b00, 2'b00, 2'b01);
        cyc("E2", 2'b11, NS,  SGL, 1, NS,  SGL, 1, 2'b01, 2'b00, 2'b10);
        cyc("E3", 2'b11, NS,  SGL, 1, NS,  SGL, 1, 2'b10, 2'b01, 2'b01);
        cyc("E4", 2'b01, NS,  SGL, 1, IDL, SGL, 1, 2'b01, 2'b10, 2'b00);
        cyc("E5", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b01, 2'b01, 2'b00);
        cyc("E6", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);
`endif

        // INCR8 terminated early by IDLE
        cyc("F1", 2'b01, NS,  I8,  0, IDL, SGL, 1, 2'b00, 2'b00, 2'b01);
        cyc("F2", 2'b01, NS,  I8,  0, IDL, SGL, 1, 2'b01, 2'b00, 2'b00);
        cyc("F3", 2'b00, SQ,  I8,  0, IDL, SGL, 1, 2'b01, 2'b01, 2'b00);
        cyc("F4", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b01, 2'b01, 2'b00);
        cyc("F5", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);

        // Asynchronous reset in the middle of an INCR16
        cyc("G1", 2'b01, NS,  I16, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b01);
        cyc("G2", 2'b01, NS,  I16, 0, IDL, SGL, 1, 2'b01, 2'b00, 2'b00);
        cyc("G3", 2'b00, SQ,  I16, 0, IDL, SGL, 1, 2'b01, 2'b01, 2'b00);
        #6 HRESET = 1'b1;
        #1;
        check("G3.async_addr_sel", addr_sel, 2'b00);
        check("G3.async_data_sel", data_sel, 2'b00);
        check("G3.async_hwait",    hwait,    2'b00);
        #4 HRESET = 1'b0;
        cyc("G4", 2'b11, NS,  SGL, 0, NS,  SGL, 1, 2'b00, 2'b00, 2'b11);
        cyc("G5", 2'b11, NS,  SGL, 0, NS,  SGL, 1, 2'b01, 2'b00, 2'b10);
        cyc("G6", 2'b10, IDL, SGL, 0, NS,  SGL, 1, 2'b10, 2'b01, 2'b00);
        cyc("G7", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b10, 2'b10, 2'b00);
        cyc("G8", 2'b00, IDL, SGL, 0, IDL, SGL, 1, 2'b00, 2'b00, 2'b00);

        repeat (2) @(posedge HCLK);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
